bin_level: RTL and testbench
============================

# bin_level

Post-FFT bin level stage between the FFT core output and the per-LED gamma LUT/PWM channels. Consumes the FFT's complex result stream and frame sync, computes |X|² per bin in a registered pipeline, scales and saturates it to PWM width, and applies per-bin peak-hold with linear decay. Runs entirely in the system clock domain, qualified by the sample strobe, with no derived clock.

## Interface
- `WIDTH`, 12, signed width of each real/imag component from the FFT
- `BINS`, 8, number of leading bins captured per frame (1..255)
- `OUT_WIDTH`, 8, level width fed to gamma LUT address
- `SHIFT`, 6, right shift applied to |X|² before saturation
- `DECAY`, 4, amount subtracted from a held level per frame when the new value is lower
- `clk` in 1: system clock (32 MHz PLL output)
- `reset` in 1: asynchronous, active-high reset
- `ce` in 1: sample strobe, same strobe driving the FFT `i_ce`; `re`/`im`/`sync` are valid only when high
- `sync` in 1: FFT frame sync; the sample presented with it is bin 0
- `re` in WIDTH: signed real part of FFT result
- `im` in WIDTH: signed imaginary part of FFT result
- `levels` out BINS*OUT_WIDTH: packed per-bin levels, bin i at `[i*OUT_WIDTH +: OUT_WIDTH]`
- `frame_done` out 1: one-cycle pulse when bin BINS-1 level has been updated

## Operation
- Bin index counter, 8 bit, advances only on `ce`: `sync`=1 → the current sample takes index 0, next index 1; else current sample takes the stored index, which then increments, saturating at BINS (never wraps).
- Reset value of index = BINS, so no bin is written until the first `sync`.
- Samples with index ≥ BINS are discarded (no write, no pulse).
- Stage 1 (on `ce`): register `re`, `im`, index, valid=1; valid=0 on cycles without `ce`.
- Stage 2: `mag = re*re + im*im`, unsigned, 2*WIDTH bits (max 2^(2*WIDTH-1), no overflow).
- Stage 3: `scaled = mag >> SHIFT`; saturate to 2^OUT_WIDTH-1. Compare against held level L[index]: if `scaled` ≥ L → L ← `scaled`; else L ← L - DECAY, floored at 0 (if L - DECAY < `scaled`, result is `scaled`).
- `frame_done` asserted in the same cycle that bin BINS-1 is written.
- `sync` arriving mid-frame restarts at bin 0; partially updated bins keep their values.
- All levels reset to 0; `frame_done` resets to 0; all pipeline valid bits reset to 0. A reset mid-pipeline drops in-flight samples.

## Timing
- Sample accepted with `ce` at edge N → `levels` slice updated, visible after edge N+3 (3-cycle latency).
- Back-to-back `ce` on consecutive cycles fully supported (throughput one sample/cycle); pipeline stages 2-3 advance every clock, gated only by valid.
- `levels` is registered; no combinational path from inputs to outputs.
- `frame_done` is high exactly one cycle per completed frame.

## Structure
- Shared package `fft_pkg`: WIDTH, BINS, OUT_WIDTH defaults and the packed level slice helper constant OUT_WIDTH; top-level uses them for the gamma/PWM generate loop.
- One sub-module: `mag_sq` — registered `re²+im²` with valid and index passthrough (stages 1-2); saturation/peak-decay and level storage stay in `bin_level`.

## Test plan
- Reset then `ce` without `sync`, re=1000 → all `levels`=0, no `frame_done`.
- `sync`+`ce` with re=100, im=0, then seven samples re=0 → bin0 = 10000>>6 = 156, bins1-7 = 0; `frame_done` one cycle, 3 cycles after the 8th `ce`.
- re=-2048, im=-2048 on bin 2 → 2^23>>6 saturates to 255.
- Frame 1 bin0=200, then frames with bin0=0 → 196, 192, 188 … reaching 0 after 50 frames, never negative; a new value 150 on a frame where held level is 160 yields 156, then 150 is retained on the next frame once 152 decays below it.
- Consecutive-cycle `ce` for 8 samples vs. `ce` every 4 cycles → identical `levels`; `sync` at sample 4 mid-frame → next sample written to bin 0.
- Assert `reset` while a sample is in stage 2 → no write after release, `levels`=0, `frame_done` stays low.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants for the FFT back end: component/level widths, bin count and
// the default scaling applied between |X|^2 and the gamma LUT address.
package fft_pkg;

    localparam int DEF_WIDTH     = 12;
    localparam int DEF_BINS      = 8;
    localparam int DEF_OUT_WIDTH = 8;
    localparam int DEF_SHIFT     = 6;
    localparam int DEF_DECAY     = 4;

    // Bin index is 8 bits so it can hold BINS itself as the "idle" value.
    localparam int IDX_W = 8;

    typedef logic [IDX_W-1:0] bin_idx_t;

    // Low bit of bin i inside the packed levels vector.
    function automatic int level_lsb(input int bin, input int out_width);
        return bin * out_width;
    endfunction

endpackage

// File: rtl/bin_level_if.sv
// FFT result stream in, packed per-bin levels and frame pulse out.
interface bin_level_if #(
    parameter int WIDTH     = fft_pkg::DEF_WIDTH,
    parameter int BINS      = fft_pkg::DEF_BINS,
    parameter int OUT_WIDTH = fft_pkg::DEF_OUT_WIDTH
);
    logic                        ce;
    logic                        sync;
    logic signed [WIDTH-1:0]     re;
    logic signed [WIDTH-1:0]     im;
    logic [BINS*OUT_WIDTH-1:0]   levels;
    logic                        frame_done;

    modport master (
        output ce, sync, re, im,
        input  levels, frame_done
    );

    modport slave (
        input  ce, sync, re, im,
        output levels, frame_done
    );
endinterface

// File: rtl/bin_level_mag.sv
// Registered |X|^2: stage 1 captures the strobed sample, stage 2 holds re^2+im^2,
// with valid and bin index carried alongside.
module mag_sq
    import fft_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce_i,
    input  logic signed [WIDTH-1:0] re_i,
    input  logic signed [WIDTH-1:0] im_i,
    input  bin_idx_t                idx_i,
    output logic                    valid_o,
    output logic [2*WIDTH-1:0]      mag_o,
    output bin_idx_t                idx_o
);

    localparam int MAG_W = 2 * WIDTH;

    logic signed [WIDTH-1:0] re_q, re_d;
    logic signed [WIDTH-1:0] im_q, im_d;
    bin_idx_t                s1_idx_q, s1_idx_d;
    logic                    s1_valid_q;

    logic signed [MAG_W-1:0] re_ext, im_ext;
    logic [MAG_W-1:0]        mag_q, mag_d;
    bin_idx_t                s2_idx_q;
    logic                    s2_valid_q;

    always_comb begin
        re_d     = re_q;
        im_d     = im_q;
        s1_idx_d = s1_idx_q;
        if (ce_i) begin
            re_d     = re_i;
            im_d     = im_i;
            s1_idx_d = idx_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            re_q       <= '0;
            im_q       <= '0;
            s1_idx_q   <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            re_q       <= re_d;
            im_q       <= im_d;
            s1_idx_q   <= s1_idx_d;
            s1_valid_q <= ce_i;
        end
    end

    // Sum of two squares peaks at 2^(2*WIDTH-1) and fits unsigned in MAG_W bits.
    always_comb begin
        re_ext = {{WIDTH{re_q[WIDTH-1]}}, re_q};
        im_ext = {{WIDTH{im_q[WIDTH-1]}}, im_q};
        mag_d  = $unsigned(re_ext * re_ext + im_ext * im_ext);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag_q      <= '0;
            s2_idx_q   <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            mag_q      <= mag_d;
            s2_idx_q   <= s1_idx_q;
            s2_valid_q <= s1_valid_q;
        end
    end

    assign valid_o = s2_valid_q;
    assign mag_o   = mag_q;
    assign idx_o   = s2_idx_q;

endmodule

// File: rtl/bin_level.sv
// Per-bin display level: |X|^2 scaled and saturated to OUT_WIDTH, then peak-held
// with linear decay. Three-cycle latency from strobed sample to level register.
module bin_level
    import fft_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BINS      = DEF_BINS,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int SHIFT     = DEF_SHIFT,
    parameter int DECAY     = DEF_DECAY
) (
    input  logic      clk,
    input  logic      reset,
    bin_level_if.slave bus
);

    localparam int                   MAG_W     = 2 * WIDTH;
    localparam bin_idx_t             BINS_IDX  = IDX_W'(BINS);
    localparam bin_idx_t             LAST_IDX  = IDX_W'(BINS - 1);
    localparam logic [OUT_WIDTH-1:0] DECAY_V   = OUT_WIDTH'(DECAY);
    localparam logic [OUT_WIDTH-1:0] LEVEL_MAX = '1;

    bin_idx_t idx_q, idx_d, cur_idx;

    // Index parks at BINS after the last bin (and after reset) so stray samples
    // outside a frame are dropped instead of wrapping onto bin 0.
    always_comb begin
        cur_idx = bus.sync ? '0 : idx_q;
        idx_d   = idx_q;
        if (bus.ce) begin
            idx_d = (cur_idx >= BINS_IDX) ? BINS_IDX : cur_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= BINS_IDX;
        end else begin
            idx_q <= idx_d;
        end
    end

    logic             mag_valid;
    logic [MAG_W-1:0] mag;
    bin_idx_t         mag_idx;

    mag_sq #(
        .WIDTH (WIDTH)
    ) u_mag_sq (
        .clk     (clk),
        .reset   (reset),
        .ce_i    (bus.ce),
        .re_i    (bus.re),
        .im_i    (bus.im),
        .idx_i   (cur_idx),
        .valid_o (mag_valid),
        .mag_o   (mag),
        .idx_o   (mag_idx)
    );

    logic [MAG_W-1:0]     shifted;
    logic [OUT_WIDTH-1:0] sc_q, sc_d;
    bin_idx_t             sc_idx_q;
    logic                 sc_valid_q, sc_valid_d;

    always_comb begin
        shifted    = mag >> SHIFT;
        sc_d       = (|shifted[MAG_W-1:OUT_WIDTH]) ? LEVEL_MAX : shifted[OUT_WIDTH-1:0];
        sc_valid_d = mag_valid && (mag_idx < BINS_IDX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc_q       <= '0;
            sc_idx_q   <= '0;
            sc_valid_q <= 1'b0;
        end else begin
            sc_q       <= sc_d;
            sc_idx_q   <= mag_idx;
            sc_valid_q <= sc_valid_d;
        end
    end

    for (genvar gi = 0; gi < BINS; gi++) begin : g_bin
        logic [OUT_WIDTH-1:0] level_q, level_d, decayed;
        logic                 wr_en;

        // Decay never drops below the incoming value: max(L - DECAY, scaled).
        always_comb begin
            wr_en   = sc_valid_q && (sc_idx_q == IDX_W'(gi));
            decayed = (level_q >= DECAY_V) ? level_q - DECAY_V : '0;
            level_d = level_q;
            if (wr_en) begin
                if ((sc_q >= level_q) || (decayed < sc_q)) begin
                    level_d = sc_q;
                end else begin
                    level_d = decayed;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                level_q <= '0;
            end else begin
                level_q <= level_d;
            end
        end

        assign bus.levels[level_lsb(gi, OUT_WIDTH) +: OUT_WIDTH] = level_q;
    end

    logic frame_done_q, frame_done_d;

    always_comb begin
        frame_done_d = sc_valid_q && (sc_idx_q == LAST_IDX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bin_level.sv
// Directed bench for bin_level: hand-computed levels for reset, scaling,
// saturation, peak decay, strobe spacing, mid-frame sync and reset mid-pipeline.
module tb_bin_level;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bin_level_if bus ();

    bin_level u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int fd_cnt       = 0;

    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) fd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lvl(input int i);
        return int'(bus.levels[i*DEF_OUT_WIDTH +: DEF_OUT_WIDTH]);
    endfunction

    task automatic drive(input logic c, input logic s, input int r, input int i);
        @(negedge clk);
        bus.ce   = c;
        bus.sync = s;
        bus.re   = DEF_WIDTH'(r);
        bus.im   = DEF_WIDTH'(i);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        bus.ce   = 1'b0;
        bus.sync = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_frame(input int re_v[8], input int im_v[8], input int gap);
        for (int b = 0; b < 8; b++) begin
            drive(1'b1, b == 0, re_v[b], im_v[b]);
            if (gap > 0) idle(gap);
        end
        idle(5);
        $display("[TB] frame sent: bin0 re=%0d im=%0d gap=%0d -> bin0 level %0d",
                 re_v[0], im_v[0], gap, lvl(0));
    endtask

    task automatic send_bin0_frame(input int re0, input int im0);
        send_frame('{re0, 0, 0, 0, 0, 0, 0, 0}, '{im0, 0, 0, 0, 0, 0, 0, 0}, 0);
    endtask

    initial begin
        int fd_base;
        int expv;
        int pat_re[8];
        int pat_im[8];
        int pat_exp[8];

        reset    = 1'b1;
        bus.ce   = 1'b0;
        bus.sync = 1'b0;
        bus.re   = '0;
        bus.im   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and strobes before any sync
        check_eq("rst_levels", bus.levels, 64'd0);
        check_eq("rst_fd", bus.frame_done, 1'b0);
        fd_base = fd_cnt;
        repeat (4) drive(1'b1, 1'b0, 1000, 0);
        idle(6);
        check_eq("nosync_levels", bus.levels, 64'd0);
        check_eq("nosync_fd", fd_cnt - fd_base, 0);
        $display("[TB] no-sync samples sent");

        // Basic frame: latency and frame_done timing
        fd_base = fd_cnt;
        drive(1'b1, 1'b1, 100, 0);
        for (int s = 1; s < 8; s++) begin
            @(negedge clk);
            if (s == 3) check_eq("lat_pre_bin0", lvl(0), 0);
            if (s == 4) check_eq("lat_bin0", lvl(0), 156);
            bus.sync = 1'b0;
            bus.re   = '0;
            bus.im   = '0;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) bus.ce = 1'b0;
            check_eq($sformatf("fd_edge%0d", k), bus.frame_done, (k == 3));
        end
        check_eq("frame1_bin0", lvl(0), 156);
        for (int b = 1; b < 8; b++) check_eq($sformatf("frame1_bin%0d", b), lvl(b), 0);
        check_eq("frame1_fd_cnt", fd_cnt - fd_base, 1);
        $display("[TB] frame sent: bin0 re=100 -> bin0 level %0d", lvl(0));

        // Saturation on bin 2, bin 0 decays by 4
        send_frame('{0, 0, -2048, 0, 0, 0, 0, 0}, '{0, 0, -2048, 0, 0, 0, 0, 0}, 0);
        check_eq("sat_bin2", lvl(2), 255);
        check_eq("sat_bin0_decay", lvl(0), 152);

        // Linear decay from 200 down to the floor
        do_reset();
        send_bin0_frame(80, 80);
        check_eq("decay_start", lvl(0), 200);
        for (int k = 1; k <= 51; k++) begin
            send_bin0_frame(0, 0);
            expv = 200 - 4 * k;
            if (expv < 0) expv = 0;
            check_eq($sformatf("decay_k%0d", k), lvl(0), expv);
        end

        // New value below held level: max(L - DECAY, scaled)
        do_reset();
        send_bin0_frame(96, 32);
        check_eq("hold_160", lvl(0), 160);
        send_bin0_frame(98, 0);
        check_eq("hold_156", lvl(0), 156);
        send_bin0_frame(98, 0);
        check_eq("hold_152", lvl(0), 152);
        send_bin0_frame(98, 0);
        check_eq("hold_150a", lvl(0), 150);
        send_bin0_frame(98, 0);
        check_eq("hold_150b", lvl(0), 150);

        // Back-to-back strobes versus one strobe every 4 cycles
        pat_re  = '{20, 40, 60, 80, 100, 120, 0, -50};
        pat_im  = '{0, 0, 0, 0, 0, 0, -127, 0};
        pat_exp = '{6, 25, 56, 100, 156, 225, 252, 39};
        do_reset();
        fd_base = fd_cnt;
        send_frame(pat_re, pat_im, 0);
        for (int b = 0; b < 8; b++) check_eq($sformatf("b2b_bin%0d", b), lvl(b), pat_exp[b]);
        check_eq("b2b_fd_cnt", fd_cnt - fd_base, 1);
        do_reset();
        fd_base = fd_cnt;
        send_frame(pat_re, pat_im, 3);
        for (int b = 0; b < 8; b++) check_eq($sformatf("gap_bin%0d", b), lvl(b), pat_exp[b]);
        check_eq("gap_fd_cnt", fd_cnt - fd_base, 1);

        // Sync arriving at sample 4 restarts at bin 0
        do_reset();
        fd_base = fd_cnt;
        drive(1'b1, 1'b1, 20, 0);
        drive(1'b1, 1'b0, 40, 0);
        drive(1'b1, 1'b0, 40, 0);
        drive(1'b1, 1'b0, 40, 0);
        drive(1'b1, 1'b1, 100, 0);
        drive(1'b1, 1'b0, 60, 0);
        idle(6);
        pat_exp = '{156, 56, 25, 25, 0, 0, 0, 0};
        for (int b = 0; b < 8; b++) check_eq($sformatf("midsync_bin%0d", b), lvl(b), pat_exp[b]);
        check_eq("midsync_fd_cnt", fd_cnt - fd_base, 0);
        $display("[TB] mid-frame sync sequence sent");

        // Reset while the last bin of a frame sits in stage 2
        do_reset();
        fd_base = fd_cnt;
        drive(1'b1, 1'b1, 0, 0);
        repeat (6) drive(1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 100, 0);
        @(negedge clk);
        bus.ce = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(8);
        check_eq("midrst_levels", bus.levels, 64'd0);
        check_eq("midrst_fd_cnt", fd_cnt - fd_base, 0);
        $display("[TB] reset applied mid-pipeline");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
